// File: rtl/bsh_pipe.sv
`default_nettype none
// ============================================================================
// Module  : bsh_pipe
// Brief   : Pipelined barrel shifter (ASR/LSR/LSL/ROR) with optional rounding,
//           one shift layer per registered stage, valid/ready flow control.
// Rev     : 1.0
// ============================================================================
module bsh_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic [1:0]       in_mode,
    input  logic             in_round,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] C_ASR  = 2'b00;
    localparam logic [1:0] C_LSR  = 2'b01;
    localparam logic [1:0] C_LSL  = 2'b10;
    localparam logic [1:0] C_ROR  = 2'b11;
    localparam int         C_LAST = SHW - 1;

    for (genvar i = 0; i < SHW; i++) begin : g_stage
        localparam int K = 1 << i;

        logic             w_vin;
        logic             w_gin;
        logic             w_rin;
        logic [WIDTH-1:0] w_din;
        logic [SHW-1:0]   w_sin;
        logic [1:0]       w_min;
        logic [TAG_W-1:0] w_tin;
        logic             w_rdy;
        logic             w_rdy_dn;

        logic             valid_q;
        logic             guard_q;
        logic             round_q;
        logic [WIDTH-1:0] data_q;
        logic [SHW-1:0]   shift_q;
        logic [1:0]       mode_q;
        logic [TAG_W-1:0] tag_q;

        logic [WIDTH-1:0] data_d;
        logic             guard_d;

        if (i == 0) begin : g_head
            assign w_vin = in_valid;
            assign w_gin = 1'b0;
            assign w_rin = in_round;
            assign w_din = in_data;
            assign w_sin = in_shift;
            assign w_min = in_mode;
            assign w_tin = in_tag;
        end else begin : g_body
            assign w_vin = g_stage[i-1].valid_q;
            assign w_gin = g_stage[i-1].guard_q;
            assign w_rin = g_stage[i-1].round_q;
            assign w_din = g_stage[i-1].data_q;
            assign w_sin = g_stage[i-1].shift_q;
            assign w_min = g_stage[i-1].mode_q;
            assign w_tin = g_stage[i-1].tag_q;
        end

        if (i == C_LAST) begin : g_rdy_out
            assign w_rdy_dn = out_ready;
        end else begin : g_rdy_mid
            assign w_rdy_dn = g_stage[i+1].w_rdy;
        end

        // An empty stage always accepts, so bubbles collapse under stall.
        assign w_rdy = !valid_q || w_rdy_dn;

        always_comb begin
            data_d  = w_din;
            guard_d = w_gin;
            if (w_sin[i]) begin
                case (w_min)
                    C_ASR:   data_d = $signed(w_din) >>> K;
                    C_LSR:   data_d = w_din >> K;
                    C_LSL:   data_d = w_din << K;
                    C_ROR:   data_d = (w_din >> K) | (w_din << (WIDTH - K));
                    default: data_d = w_din;
                endcase
                if (!w_min[1]) begin
                    guard_d = w_din[K-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                guard_q <= 1'b0;
                round_q <= 1'b0;
                data_q  <= '0;
                shift_q <= '0;
                mode_q  <= '0;
                tag_q   <= '0;
            end else if (w_rdy) begin
                valid_q <= w_vin;
                guard_q <= guard_d;
                round_q <= w_rin;
                data_q  <= data_d;
                shift_q <= w_sin;
                mode_q  <= w_min;
                tag_q   <= w_tin;
            end
        end
    end

    // Round-to-nearest: add back the last bit shifted out (right shifts only).
    logic w_rnd;
    logic w_unused;

    assign w_rnd     = g_stage[C_LAST].round_q && !g_stage[C_LAST].mode_q[1]
                       && g_stage[C_LAST].guard_q;
    assign in_ready  = g_stage[0].w_rdy;
    assign out_valid = g_stage[C_LAST].valid_q;
    assign out_data  = g_stage[C_LAST].data_q + {{(WIDTH-1){1'b0}}, w_rnd};
    assign out_tag   = g_stage[C_LAST].tag_q;
    assign w_unused  = ^{g_stage[C_LAST].shift_q, g_stage[C_LAST].mode_q[0]};

endmodule
`default_nettype wire

// File: tb/tb_bsh_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_bsh_pipe
// Brief   : Self-checking bench for bsh_pipe (vector table + scoreboard).
// Rev     : 1.0
// ============================================================================
module tb_bsh_pipe;
    localparam int W  = 16;
    localparam int S  = 4;
    localparam int T  = 4;
    localparam int NV = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [S-1:0] in_shift;
    logic [1:0]   in_mode;
    logic         in_round;
    logic [T-1:0] in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [T-1:0] out_tag;

    always #5 clk = ~clk;

    bsh_pipe #(.WIDTH(W), .SHW(S), .TAG_W(T)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shift(in_shift), .in_mode(in_mode), .in_round(in_round), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    typedef struct { logic [W-1:0] d; logic [S-1:0] s; logic [1:0] m; logic r; logic [T-1:0] t; logic [W-1:0] e; } beat_t;
    typedef struct { logic [W-1:0] d; logic [T-1:0] t; } exp_t;
    typedef struct { logic [W-1:0] d; logic [S-1:0] s; logic [1:0] m; logic r; logic [W-1:0] e; } vec_t;

    beat_t pend[$];
    exp_t  sb[$];
    vec_t  tbl[NV];

    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   out_first = 0;
    int   out_last = 0;
    int   out_cnt = 0;
    logic gate = 1'b0;

    logic         stall_q = 1'b0;
    logic [W-1:0] hold_d;
    logic [T-1:0] hold_t;
    logic [W-1:0] rd;
    logic [S-1:0] rs;
    logic [1:0]   rm;
    logic         rr;

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [S-1:0] s,
                                           input logic [1:0] m, input logic r);
        logic [W-1:0] res;
        logic         g;
        int           k;
        k = int'(s);
        g = (k > 0 && !m[1]) ? d[k-1] : 1'b0;
        case (m)
            2'b00:   res = $signed(d) >>> k;
            2'b01:   res = d >> k;
            2'b10:   res = d << k;
            default: res = (k == 0) ? d : ((d >> k) | (d << (W - k)));
        endcase
        if (r && !m[1]) res = res + {{(W-1){1'b0}}, g};
        return res;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] need);
        n_vec++;
        if (got !== need) begin
            n_mis++;
            $display("FAIL %s: got %h, need %h", nm, got, need);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain(input string nm, input int budget);
        int c;
        c = 0;
        while ((pend.size() != 0 || sb.size() != 0) && c < budget) begin
            tick(1);
            c++;
        end
        if (c >= budget) begin
            n_vec++;
            n_mis++;
            $display("FAIL %s_timeout: got %0d beats outstanding, need 0", nm, pend.size() + sb.size());
        end
    endtask

    task automatic push_rand(input logic [T-1:0] t);
        rd = W'($urandom);
        rs = S'($urandom);
        rm = 2'($urandom);
        rr = 1'($urandom);
        pend.push_back('{rd, rs, rm, rr, t, model(rd, rs, rm, rr)});
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Input driver: presents the head of the pending queue.
    initial begin
        in_valid = 1'b0; in_data = '0; in_shift = '0; in_mode = '0; in_round = 1'b0; in_tag = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && gate && pend.size() > 0) begin
                in_valid = 1'b1;
                in_data  = pend[0].d;
                in_shift = pend[0].s;
                in_mode  = pend[0].m;
                in_round = pend[0].r;
                in_tag   = pend[0].t;
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (in_valid && in_ready && !rst) begin
            sb.push_back('{pend[0].e, pend[0].t});
            void'(pend.pop_front());
            acc_cyc = cyc;
        end
    end

    // Output monitor: scoreboard compare and stall-hold check.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (stall_q && !rst) begin
            n_vec++;
            if (!out_valid || out_data !== hold_d || out_tag !== hold_t) begin
                n_mis++;
                $display("FAIL stall_hold: got v=%0b d=%h t=%h, need v=1 d=%h t=%h",
                         out_valid, out_data, out_tag, hold_d, hold_t);
            end
        end
        stall_q = out_valid && !out_ready && !rst;
        hold_d  = out_data;
        hold_t  = out_tag;
        if (out_valid && out_ready && !rst) begin
            if (out_cnt == 0) out_first = cyc;
            out_last = cyc;
            out_cnt++;
            n_vec++;
            if (sb.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_beat: got d=%h t=%h, need no beat", out_data, out_tag);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.d || out_tag !== e.t) begin
                    n_mis++;
                    $display("FAIL beat: got d=%h t=%h, need d=%h t=%h", out_data, out_tag, e.d, e.t);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, need finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{16'h8000, 4'd4,  2'b00, 1'b0, 16'hF800};
        tbl[1]  = '{16'h8000, 4'd4,  2'b01, 1'b0, 16'h0800};
        tbl[2]  = '{16'h0001, 4'd15, 2'b10, 1'b0, 16'h8000};
        tbl[3]  = '{16'h0001, 4'd1,  2'b11, 1'b0, 16'h8000};
        tbl[4]  = '{16'h1234, 4'd8,  2'b11, 1'b0, 16'h3412};
        tbl[5]  = '{16'hA5C3, 4'd0,  2'b00, 1'b1, 16'hA5C3};
        tbl[6]  = '{16'hA5C3, 4'd0,  2'b01, 1'b0, 16'hA5C3};
        tbl[7]  = '{16'hA5C3, 4'd0,  2'b10, 1'b0, 16'hA5C3};
        tbl[8]  = '{16'hA5C3, 4'd0,  2'b11, 1'b1, 16'hA5C3};
        tbl[9]  = '{16'h0006, 4'd2,  2'b00, 1'b1, 16'h0002};
        tbl[10] = '{16'hFFFB, 4'd1,  2'b00, 1'b1, 16'hFFFE};
        tbl[11] = '{16'hFFFF, 4'd1,  2'b01, 1'b1, 16'h8000};
        tbl[12] = '{16'h0003, 4'd1,  2'b10, 1'b1, 16'h0006};
        tbl[13] = '{16'h8001, 4'd15, 2'b11, 1'b1, 16'h0003};
        tbl[14] = '{16'h7FFF, 4'd15, 2'b01, 1'b1, 16'h0001};
        tbl[15] = '{16'h8000, 4'd15, 2'b00, 1'b0, 16'hFFFF};

        out_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_tag",   32'(out_tag),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Single-beat latency.
        tick(1);
        out_ready = 1'b1;
        out_cnt = 0;
        pend.push_back('{16'h8000, 4'd4, 2'b00, 1'b0, 4'hA, 16'hF800});
        gate = 1'b1;
        drain("latency", 50);
        chk("latency", 32'(out_first - acc_cyc), 32'd4);

        // Directed table, back to back.
        tick(2);
        out_cnt = 0;
        for (int i = 0; i < NV; i++)
            pend.push_back('{tbl[i].d, tbl[i].s, tbl[i].m, tbl[i].r, T'(i), tbl[i].e});
        drain("table", 200);
        chk("throughput", 32'(out_last - out_first), 32'(NV - 1));

        // Backpressure: capacity is SHW beats.
        tick(2);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_rand(T'(i));
        tick(8);
        @(negedge clk);
        chk("bp_accepted",  32'(sb.size()),  32'd4);
        chk("bp_in_ready",  32'(in_ready),   32'd0);
        chk("bp_out_valid", 32'(out_valid),  32'd1);
        chk("bp_out_tag",   32'(out_tag),    32'd0);
        chk("bp_out_data",  32'(out_data),   32'(sb[0].d));
        tick(1);
        out_ready = 1'b1;
        drain("bp", 100);

        // Reset with beats in flight.
        tick(2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_rand(T'(i + 8));
        tick(6);
        chk("rst_inflight", 32'(sb.size()), 32'd3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        sb.delete();
        pend.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data",  32'(out_data),  32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        tick(1);
        out_ready = 1'b1;
        tick(10);

        // Random flow control against the reference model.
        for (int i = 0; i < 300; i++) push_rand(T'(i));
        for (int c = 0; c < 3000 && (pend.size() != 0 || sb.size() != 0); c++) begin
            gate      = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            tick(1);
        end
        gate = 1'b1;
        out_ready = 1'b1;
        drain("random", 200);
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsh_pipe.md
Name: bsh_pipe

Overview:
- Parametrised, pipelined barrel shifter for the CORDIC datapath and its pre/post-normalisation logic.
- Supports arithmetic right, logical right, logical left and rotate right, with optional round-to-nearest on right shifts.
- Each shift layer (1, 2, 4, … bits) is a registered pipeline stage with valid/ready flow control and a sideband tag, e.g. the CORDIC iteration index.

Parameters:
- WIDTH, 16, data width in bits; power of two, ≥4.
- SHW, $clog2(WIDTH), shift-amount width; also the number of pipeline stages.
- TAG_W, 4, sideband tag width; carried unmodified alongside the data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  WIDTH  operand.
- in_shift  in  SHW  shift amount, 0..WIDTH-1.
- in_mode  in  2  00 ASR, 01 LSR, 10 LSL, 11 ROR.
- in_round  in  1  round-to-nearest enable; honoured for ASR/LSR only.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  WIDTH  shifted (and optionally rounded) result.
- out_tag  out  TAG_W  tag of the beat on out_data.

Behaviour:
- Reset:
  - All stage valid bits clear, so out_valid=0.
  - Stage data, tag, mode, shift and guard registers clear to 0, so out_data=0 and out_tag=0.
  - in_ready=1 in the cycle after reset deasserts.
  - Asserting rst mid-operation discards every in-flight beat; nothing is emitted afterwards.
- Pipeline structure:
  - Stage i (i=0..SHW-1) holds valid v[i], data, guard g, and the beat's remaining control (shift, mode, round, tag).
  - Stage 0 takes its input from the ports; stage i takes it from stage i-1.
  - Stage i shifts by 2^i when shift bit i is set; otherwise data passes through unchanged.
- Layer functions, per mode, for a shift by k:
  - ASR: fill the top k bits with the current MSB.
  - LSR: zero-fill the top k bits.
  - LSL: zero-fill the bottom k bits.
  - ROR: bits shifted out of the bottom re-enter at the top.
- Guard bit:
  - Cleared on entry.
  - In ASR/LSR, when a layer shifts by k, g takes bit k-1 of that layer's input; otherwise g is held.
  - The result is that g equals the last bit shifted out.
- Rounding:
  - Applies at the output of stage SHW-1 when in_round=1 and the mode is ASR/LSR.
  - out_data = shifted value + g, with the sum taken modulo 2^WIDTH. Overflow cannot occur for shift ≥1.
  - For shift=0, g=0, so there is no change.
- Latency: exactly SHW cycles from accept (in_valid&&in_ready) to out_valid, provided there is no backpressure.
- Flow control:
  - r[SHW]=out_ready; r[i] = !v[i] || r[i+1]; in_ready = r[0].
  - Stage i loads when r[i]=1.
  - v[i] loads in_valid for stage 0, and v[i-1] for later stages.
  - This creates a combinational path from out_ready to in_ready, which is permitted.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Ordering and capacity:
  - Beats are emitted in accept order, never dropped and never duplicated.
  - Maximum occupancy is SHW beats.
- Outputs under stall: while out_valid=1 and out_ready=0, out_data and out_tag are held stable.
- Simultaneous events: a beat can enter and a beat can exit in the same cycle when all stages are full and out_ready=1, giving sustained throughput of 1 beat/cycle.
- Out-of-range inputs:
  - Shift is in range by construction, since its width is SHW.
  - in_round is ignored for LSL and ROR.
  - in_mode is fully decoded; there are no illegal codes.

Test Plan (WIDTH=16, SHW=4):
- ASR: in_data=0x8000, shift 4, round 0 → out_data=0xF800, out_valid exactly 4 cycles after accept. Same beat as LSR → 0x0800.
- LSL and ROR:
  - LSL of 0x0001 by 15 → 0x8000.
  - ROR of 0x0001 by 1 → 0x8000.
  - ROR of 0x1234 by 8 → 0x3412.
  - Shift 0 in any mode → data unchanged.
- Rounding:
  - ASR of 0x0006 by 2, round 1 → 0x0002 (unrounded 0x0001).
  - ASR of 0xFFFB (-5) by 1, round 1 → 0xFFFE (-2).
  - LSR of 0xFFFF by 1, round 1 → 0x8000.
  - LSL of 0x0003 by 1, round 1 → 0x0006 (rounding ignored).
- Backpressure:
  - Hold out_ready=0 and offer 6 beats with tags 0..5 → 4 beats accepted, then in_ready=0. out_data/out_tag stay stable.
  - Release out_ready → tags emerge 0..5 in order, one per cycle, with none lost.
- Throughput and bubbles:
  - Continuous in_valid with out_ready=1 → one result per cycle after the 4-cycle fill.
  - Randomly toggle in_valid/out_ready → results are bit-exact against a reference model and in order.
- Reset mid-stream: 3 beats in flight, assert rst for 1 cycle → out_valid=0 next cycle, out_data=0, no stale beat ever emitted, in_ready=1.
